// File: rtl/keccak_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : keccak_pkg                                                      |
// | Brief  : Shared Keccak core types: step-unit select encodings, round     |
// |          index sizing and the round controller state type.               |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package keccak_pkg;

    localparam int STEP_SEL_WIDTH     = 3;
    localparam int ROUND_INDEX_SIZE   = 5;
    localparam int NUM_ROUNDS_DEFAULT = 24;

    typedef logic [STEP_SEL_WIDTH-1:0]   step_sel_t;
    typedef logic [ROUND_INDEX_SIZE-1:0] round_idx_t;

    // Step-unit mux select encodings; IDLE_STEP parks the mux when not running.
    localparam step_sel_t THETA     = 3'd0;
    localparam step_sel_t RHO       = 3'd1;
    localparam step_sel_t PI        = 3'd2;
    localparam step_sel_t CHI       = 3'd3;
    localparam step_sel_t IOTA      = 3'd4;
    localparam step_sel_t IDLE_STEP = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/keccak_round_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : keccak_round_ctrl_if                                            |
// | Brief  : Handshake and step-unit control bundle between the absorb/      |
// |          squeeze control (master) and the round controller (slave).      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface keccak_round_ctrl_if
    import keccak_pkg::*;
();
    logic       start_i;
    logic       halt_i;
    logic       ready_o;
    step_sel_t  step_sel_o;
    round_idx_t round_index_o;
    logic       state_we_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i, halt_i,
        input  ready_o, step_sel_o, round_index_o, state_we_o, busy_o, done_o
    );

    modport slave (
        input  start_i, halt_i,
        output ready_o, step_sel_o, round_index_o, state_we_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/keccak_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : keccak_round_ctrl                                               |
// | Brief  : Sequences the combinational Keccak step unit through theta,     |
// |          rho, pi, chi, iota for every round of Keccak-f[1600], driving   |
// |          the step select, round index and state-register write enable.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    keccak_round_ctrl_if.slave ctrl
);

    localparam round_idx_t c_LAST_ROUND = ROUND_INDEX_SIZE'(NUM_ROUNDS - 1);

    ctrl_state_e r_state;
    step_sel_t   r_step;
    round_idx_t  r_round;

    ctrl_state_e w_state_nxt;
    step_sel_t   w_step_nxt;
    round_idx_t  w_round_nxt;

    logic        w_ready;
    logic        w_busy;
    logic        w_done;
    logic        w_we;
    step_sel_t   w_step_sel;

    // State and counter registers; reset parks the controller idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= THETA;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_round <= w_round_nxt;
        end
    end

    // Next-state / counter advance and output decode. step_sel and round
    // index depend only on registered state; only the write enable sees halt.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_round_nxt = r_round;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_we        = 1'b0;
        w_step_sel  = IDLE_STEP;

        case (r_state)
            IDLE: begin
                w_ready     = 1'b1;
                w_step_nxt  = THETA;
                w_round_nxt = '0;
                if (ctrl.start_i) begin
                    w_state_nxt = RUN;
                end
            end

            RUN: begin
                w_busy = 1'b1;
                if (r_step > IOTA) begin
                    // Corrupted step counter: abandon the permutation.
                    w_state_nxt = IDLE;
                    w_step_nxt  = THETA;
                    w_round_nxt = '0;
                end else begin
                    w_step_sel = r_step;
                    w_we       = !ctrl.halt_i;
                    if (!ctrl.halt_i) begin
                        if (r_step == IOTA) begin
                            w_step_nxt = THETA;
                            if (r_round == c_LAST_ROUND) begin
                                w_state_nxt = DONE;
                                w_round_nxt = '0;
                            end else begin
                                w_round_nxt = r_round + ROUND_INDEX_SIZE'(1);
                            end
                        end else begin
                            w_step_nxt = r_step + STEP_SEL_WIDTH'(1);
                        end
                    end
                end
            end

            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = IDLE;
                w_step_nxt  = THETA;
                w_round_nxt = '0;
            end

            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = THETA;
                w_round_nxt = '0;
            end
        endcase
    end

    assign ctrl.ready_o       = w_ready;
    assign ctrl.busy_o        = w_busy;
    assign ctrl.done_o        = w_done;
    assign ctrl.state_we_o    = w_we;
    assign ctrl.step_sel_o    = w_step_sel;
    assign ctrl.round_index_o = r_round;

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : tb_keccak_round_ctrl                                            |
// | Brief  : Directed self-checking bench for the Keccak round controller.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_keccak_round_ctrl;
    import keccak_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    keccak_round_ctrl_if m ();
    keccak_round_ctrl_if s ();

    keccak_round_ctrl #(.NUM_ROUNDS(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (m)
    );

    keccak_round_ctrl #(.NUM_ROUNDS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        start;
        logic        halt;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [12];

    // Packed view: {ready, busy, done, we, step_sel[2:0], round[4:0]}
    function automatic logic [11:0] mk(input logic rdy, input logic bsy, input logic dn,
                                       input logic we, input logic [2:0] st, input logic [4:0] rd);
        return {rdy, bsy, dn, we, st, rd};
    endfunction

    function automatic logic [11:0] obs_m();
        return {m.ready_o, m.busy_o, m.done_o, m.state_we_o, m.step_sel_o, m.round_index_o};
    endfunction

    function automatic logic [11:0] obs_s();
        return {s.ready_o, s.busy_o, s.done_o, s.state_we_o, s.step_sel_o, s.round_index_o};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got rdy/bsy/done/we=%b step=%0d round=%0d, want rdy/bsy/done/we=%b step=%0d round=%0d",
                      name, act[11:8], act[7:5], act[4:0], exp[11:8], exp[7:5], exp[4:0]);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic drive_m(input logic st, input logic h);
        @(negedge clk);
        m.start_i = st;
        m.halt_i  = h;
        #1;
    endtask

    // Follows one 24-round permutation from its first RUN cycle. A halt of
    // hl cycles starts when the expected position reaches (hr, hs).
    // stop_after > 0 returns after that many cycles without finishing.
    task automatic run_perm(input logic st, input int hr, input int hs, input int hl,
                            input int stop_after);
        int  step      = 0;
        int  round     = 0;
        int  writes    = 0;
        int  cyc       = 0;
        int  halt_left = 0;
        bit  trig      = 1'b0;
        bit  fin       = 1'b0;
        logic h;
        while (!fin && cyc < 400) begin
            if (stop_after > 0 && cyc == stop_after) return;
            if (!trig && round == hr && step == hs) begin
                halt_left = hl;
                trig      = 1'b1;
            end
            h = (halt_left > 0);
            drive_m(st, h);
            cyc++;
            check($sformatf("run r%0d s%0d", round, step), obs_m(),
                  mk(1'b0, 1'b1, 1'b0, !h, 3'(step), 5'(round)));
            if (h) begin
                halt_left--;
            end else begin
                writes++;
                if (step == 4) begin
                    step = 0;
                    if (round == 23) fin = 1'b1;
                    else round++;
                end else begin
                    step++;
                end
            end
        end
        if (!fin) begin
            n_checks++;
            $display("FAIL run_perm timeout: got no completion in %0d cycles, want %0d", cyc, 120 + hl);
            return;
        end
        check_int("write count", writes, 120);
        drive_m(st, 1'b1);
        cyc++;
        check("done pulse", obs_m(), mk(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 5'd0));
        check_int("done cycle", cyc, 121 + hl);
        drive_m(st, 1'b1);
        check("ready back", obs_m(), mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 5'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] c_idle;
        c_idle = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 5'd0);

        vecs[0]  = '{1'b0, 1'b0, c_idle};
        vecs[1]  = '{1'b0, 1'b1, c_idle};                                    // halt ignored in IDLE
        vecs[2]  = '{1'b1, 1'b1, c_idle};                                    // start wins over halt
        vecs[3]  = '{1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 5'd0)};   // start in RUN ignored
        vecs[4]  = '{1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 5'd0)};
        vecs[5]  = '{1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 5'd0)};
        vecs[6]  = '{1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 5'd0)};
        vecs[7]  = '{1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 5'd0)};
        vecs[8]  = '{1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 5'd0)};
        vecs[9]  = '{1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 5'd0)};
        vecs[10] = '{1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 5'd1)};
        vecs[11] = '{1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 5'd1)};

        m.start_i = 1'b1;
        m.halt_i  = 1'b0;
        s.start_i = 1'b0;
        s.halt_i  = 1'b0;
        #1;
        check("reset main", obs_m(), c_idle);
        check("reset nr1", obs_s(), c_idle);
        repeat (3) @(negedge clk);
        m.start_i = 1'b0;
        rst_n     = 1'b1;

        // Table: halt/start interplay at the start of a permutation
        for (int i = 0; i < 12; i++) begin
            drive_m(vecs[i].start, vecs[i].halt);
            check($sformatf("vec%0d", i), obs_m(), vecs[i].exp);
        end

        // Asynchronous reset mid-permutation, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset early", obs_m(), c_idle);
        @(negedge clk);
        #1;
        check("async reset held", obs_m(), c_idle);
        rst_n = 1'b1;

        // Full permutation, no halts
        drive_m(1'b1, 1'b0);
        check("start idle", obs_m(), c_idle);
        run_perm(1'b0, -1, -1, 0, 0);

        // Three-cycle halt at round 5 CHI
        drive_m(1'b1, 1'b0);
        check("start halt3", obs_m(), c_idle);
        run_perm(1'b0, 5, 3, 3, 0);

        // Halt on the final IOTA holds the last write back one cycle
        drive_m(1'b1, 1'b0);
        check("start haltlast", obs_m(), c_idle);
        run_perm(1'b0, 23, 4, 1, 0);

        // Reset at round 12 RHO, then a fresh full permutation
        drive_m(1'b1, 1'b0);
        check("start rst12", obs_m(), c_idle);
        run_perm(1'b0, -1, -1, 0, 61);
        @(negedge clk);
        m.start_i = 1'b0;
        m.halt_i  = 1'b0;
        #1;
        check("pre-reset r12 rho", obs_m(), mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 5'd12));
        rst_n = 1'b0;
        #1;
        check("reset at r12", obs_m(), c_idle);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset hold %0d", i), obs_m(), c_idle);
        end
        rst_n = 1'b1;
        drive_m(1'b1, 1'b0);
        check("start after rst", obs_m(), c_idle);
        run_perm(1'b0, -1, -1, 0, 0);

        // start held high: back-to-back with one IDLE cycle between
        drive_m(1'b1, 1'b0);
        check("start b2b", obs_m(), c_idle);
        run_perm(1'b1, -1, -1, 0, 0);
        run_perm(1'b1, -1, -1, 0, 0);
        run_perm(1'b0, -1, -1, 0, 0);

        // NUM_ROUNDS = 1: five writes on round 0, then done
        @(negedge clk);
        s.start_i = 1'b1;
        #1;
        check("nr1 idle", obs_s(), c_idle);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s.start_i = 1'b0;
            #1;
            check($sformatf("nr1 step%0d", k), obs_s(), mk(1'b0, 1'b1, 1'b0, 1'b1, 3'(k), 5'd0));
        end
        @(negedge clk);
        #1;
        check("nr1 done", obs_s(), mk(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 5'd0));
        @(negedge clk);
        #1;
        check("nr1 ready", obs_s(), c_idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencing FSM for the combinational Keccak step unit. On each accepted start it walks the step unit through every round of Keccak-f[1600]. In each round it selects theta, rho, pi, chi and iota in order, one step per cycle, and drives the round index and the state-register write enable. Sits in the Keccak core between the absorb/squeeze control and the state register plus step unit.

Parameters:
NUM_ROUNDS, 24, number of permutation rounds; legal range 1..24.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  permutation request; accepted only when ready_o=1
ready_o  output  1  controller idle and able to accept start_i
halt_i  output  —  see below (input, 1): freeze request; pauses sequencing while high
step_sel_o  output  STEP_SEL_WIDTH  step-unit mux select (keccak_pkg step encoding)
round_index_o  output  ROUND_INDEX_SIZE  current round 0..NUM_ROUNDS-1, to the iota constant lookup
state_we_o  output  1  state register loads the step-unit output this cycle
busy_o  output  1  permutation in progress (RUN or DONE)
done_o  output  1  single-cycle pulse: permutation complete

Correction to the halt_i line above: halt_i is an input, width 1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FSM=IDLE, step counter=0, round counter=0, ready_o=1, busy_o=0, state_we_o=0, done_o=0, step_sel_o=IDLE_STEP, round_index_o=0.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from the registered state only; there is no combinational path from start_i or halt_i to step_sel_o.
- IDLE:
  - ready_o=1, step_sel_o=IDLE_STEP, state_we_o=0.
  - start_i=1 at edge T: go to RUN with round=0, step=THETA.
- RUN:
  - ready_o=0, busy_o=1, state_we_o=!halt_i.
  - step_sel_o reflects the step counter; round_index_o reflects the round counter.
  - If halt_i=0, the step advances THETA→RHO→PI→CHI→IOTA.
  - After IOTA the step wraps to THETA and the round increments.
  - After IOTA of round NUM_ROUNDS-1, go to DONE; counters clear to 0.
- Halt:
  - halt_i=1 in RUN: counters and state hold; state_we_o=0; step_sel_o and round_index_o hold their values.
  - halt_i is ignored in IDLE and DONE.
- DONE:
  - One cycle only: done_o=1, busy_o=1, state_we_o=0, step_sel_o=IDLE_STEP, ready_o=0. Then go to IDLE.
- Latency with no halts:
  - start sampled at edge T.
  - Writes occur in cycles T+1 .. T+5·NUM_ROUNDS (120 cycles for 24 rounds).
  - done_o is high in cycle T+121.
  - ready_o returns in cycle T+122.
  - Each halt cycle adds one cycle.
- start_i while ready_o=0 (RUN or DONE) is ignored and not queued.
- Simultaneous start_i and halt_i in IDLE: start is accepted.
- halt_i asserted in the cycle RUN would go to DONE: the final IOTA write does not occur; the FSM stays on round NUM_ROUNDS-1, step IOTA.
- Counter widths: step counter is 3 bits; the round counter is ROUND_INDEX_SIZE bits and never exceeds NUM_ROUNDS-1. Step counter values outside THETA..IOTA are unreachable; if they occur, the FSM recovers to IDLE.
- Reset mid-permutation: all registers return to reset values immediately; no done_o pulse is produced; the state register contents are don't-care.

Decomposition:
- keccak_pkg additions:
  - NUM_ROUNDS_DEFAULT=24.
  - typedef enum ctrl_state_e {IDLE, RUN, DONE}.
  - Reuse the existing STEP_SEL_WIDTH, ROUND_INDEX_SIZE and THETA/RHO/PI/CHI/IOTA/IDLE_STEP encodings; no new step encodings.
- No sub-module is required; counters and FSM live in one module.
- Verification may instantiate keccak_round_ctrl together with the step unit and the state register to compare against a software Keccak-f model.

Test Plan:
- Reset, then a single start_i pulse → state_we_o high for exactly 120 consecutive cycles. The step_sel_o sequence is T,R,P,Ch,I ×24 with round_index_o 0..23, followed by one done_o pulse; ready_o returns 2 cycles after the last write.
- Full integration with step unit and state register, input state all-zero, one start → state equals the Keccak-f[1600] zero-state result; lane[0][0] = 64'hF1258F7940E1DDE7.
- halt_i held high for 3 cycles starting at round 5 CHI → no writes during the halt, step_sel_o=CHI and round_index_o=5 frozen, done_o delayed by exactly 3 cycles (T+124).
- start_i held continuously high from reset → permutations back-to-back with exactly one idle cycle (the IDLE cycle) between done_o and the next first THETA write; starts during RUN and DONE are ignored.
- rst_n asserted at round 12 RHO → outputs go to reset values asynchronously (before the next clk edge); no done_o; a new start then produces a full 120-write permutation.
- NUM_ROUNDS=1 → exactly 5 writes with round_index_o=0, then done_o.
